// File: rtl/hex_display_ctrl.sv
// -----------------------------------------------------------------------------
// hex_display_ctrl
//
// Seven-segment display controller for NUM_DIGITS hexadecimal digits.
// A packed nibble vector is captured on a load strobe and shown two ways:
//   * seg_all  : every digit in parallel (boards with dedicated HEX pins)
//   * scan_*   : one digit at a time with a one-hot anode enable (scanned
//                displays), each digit held for SCAN_DIV clocks
// Leading-zero blanking and per-digit blinking are applied to both views.
//
// Parameters
//   NUM_DIGITS  number of hex digits (1..16)
//   SCAN_DIV    clocks each digit is held on the scanned bus (>=1)
//   BLINK_DIV   clocks per blink half-period (>=1)
//
// Ports
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   load        capture data_in this cycle
//   data_in     packed nibbles, digit k = [4k+3:4k]
//   lz_blank    enable leading-zero blanking (live)
//   blink_mask  bit k set: digit k blinks (live)
//   seg_all     active-low segments, digit k at [7k+6:7k], bit order g..a
//   scan_seg    active-low segments of the digit currently scanned
//   scan_an     active-low one-hot digit enable for the scanned digit
// -----------------------------------------------------------------------------
module hex_display_ctrl #(
   parameter int NUM_DIGITS = 8,
   parameter int SCAN_DIV   = 50000,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   data_in,
   input  logic                      lz_blank,
   input  logic [NUM_DIGITS-1:0]     blink_mask,
   output logic [7*NUM_DIGITS-1:0]   seg_all,
   output logic [6:0]                scan_seg,
   output logic [NUM_DIGITS-1:0]     scan_an
);

   // Counter widths; a divider of 1 still needs a 1-bit counter that sits at 0.
   localparam int SCAN_W  = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
   localparam int BLINK_W = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low g..a pattern for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      seg = SEG_BLANK;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [4*NUM_DIGITS-1:0] data_q,        data_d;
   logic [BLINK_W-1:0]      blink_cnt_q,   blink_cnt_d;
   logic                    blink_phase_q, blink_phase_d;   // 1 = visible
   logic [SCAN_W-1:0]       scan_cnt_q,    scan_cnt_d;
   logic [IDX_W-1:0]        scan_idx_q,    scan_idx_d;
   logic [7*NUM_DIGITS-1:0] seg_all_q,     seg_all_d;
   logic [6:0]              scan_seg_q,    scan_seg_d;
   logic [NUM_DIGITS-1:0]   scan_an_q,     scan_an_d;

   // --------------------------------------------------------------------------
   // Per-digit blanking and decode
   // --------------------------------------------------------------------------
   logic [NUM_DIGITS-1:0] lz_zero;       // digit k and everything above it is 0
   logic [NUM_DIGITS-1:0] digit_blank;
   logic [6:0]            digit_seg [NUM_DIGITS];

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      // Compare the whole upper slice at once rather than chaining per-digit
      // flags, which keeps the logic flat for any digit count.
      assign lz_zero[gi] = (data_q[4*NUM_DIGITS-1:4*gi] == '0);

      if (gi == 0) begin : g_lsd
         // The least-significant digit always shows, so zero reads as "0".
         assign digit_blank[gi] = blink_mask[gi] && !blink_phase_q;
      end else begin : g_upper
         assign digit_blank[gi] = (lz_blank && lz_zero[gi]) ||
                                  (blink_mask[gi] && !blink_phase_q);
      end

      assign digit_seg[gi] = digit_blank[gi] ? SEG_BLANK
                                             : hex_to_seg(data_q[4*gi +: 4]);
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      data_d        = data_q;
      blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
      blink_phase_d = blink_phase_q;
      scan_cnt_d    = scan_cnt_q + SCAN_W'(1);
      scan_idx_d    = scan_idx_q;

      if (load) begin
         data_d = data_in;
      end

      if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d   = '0;
         blink_phase_d = !blink_phase_q;
      end

      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         if (scan_idx_q == IDX_LAST) begin
            scan_idx_d = '0;
         end else begin
            scan_idx_d = scan_idx_q + IDX_W'(1);
         end
      end
   end

   // Output registers. Anode and segments are both derived from the same
   // scan_idx_q, so the registered pair always describes a single digit.
   always_comb begin
      seg_all_d  = '1;
      scan_seg_d = SEG_BLANK;
      scan_an_d  = '1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         seg_all_d[7*k +: 7] = digit_seg[k];
         if (scan_idx_q == IDX_W'(k)) begin
            scan_seg_d   = digit_seg[k];
            scan_an_d[k] = 1'b0;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_q        <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
         scan_cnt_q    <= '0;
         scan_idx_q    <= '0;
         seg_all_q     <= '1;
         scan_seg_q    <= SEG_BLANK;
         scan_an_q     <= '1;
      end else begin
         data_q        <= data_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         scan_cnt_q    <= scan_cnt_d;
         scan_idx_q    <= scan_idx_d;
         seg_all_q     <= seg_all_d;
         scan_seg_q    <= scan_seg_d;
         scan_an_q     <= scan_an_d;
      end
   end

   assign seg_all  = seg_all_q;
   assign scan_seg = scan_seg_q;
   assign scan_an  = scan_an_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hex_display_ctrl
//
// Bench for hex_display_ctrl with NUM_DIGITS=4, SCAN_DIV=2, BLINK_DIV=4.
// A behavioural model predicts the outputs from the number of edges since
// reset release and the loaded value; it is compared every cycle. Literal
// expectations from hand calculation pin the model at key points.
// -----------------------------------------------------------------------------
module tb_hex_display_ctrl;

   localparam int ND = 4;
   localparam int SD = 2;
   localparam int BD = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          load = 1'b0;
   logic [15:0]   data_in = '0;
   logic          lz_blank = 1'b0;
   logic [3:0]    blink_mask = '0;
   logic [27:0]   seg_all;
   logic [6:0]    scan_seg;
   logic [3:0]    scan_an;

   always #5 clk = ~clk;

   hex_display_ctrl #(
      .NUM_DIGITS (ND),
      .SCAN_DIV   (SD),
      .BLINK_DIV  (BD)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (load),
      .data_in    (data_in),
      .lz_blank   (lz_blank),
      .blink_mask (blink_mask),
      .seg_all    (seg_all),
      .scan_seg   (scan_seg),
      .scan_an    (scan_an)
   );

   int checks   = 0;
   int failures = 0;

   // Model state
   int          m_data  = 0;   // value the display register holds
   int          m_edges = 0;   // edges since reset release
   bit          m_valid = 1'b0;
   logic [27:0] exp_seg_all;
   logic [6:0]  exp_scan_seg;
   logic [3:0]  exp_scan_an;

   logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Hand-computed scan sequence for data 4321 loaded on the release edge.
   logic [3:0] scan_exp_an  [10] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011,
                                     4'b1011, 4'b0111, 4'b0111, 4'b1110, 4'b1110};
   logic [6:0] scan_exp_seg [10] = '{7'h40, 7'h79, 7'h24, 7'h24, 7'h30,
                                     7'h30, 7'h19, 7'h19, 7'h79, 7'h79};
   // Hand-computed digit 0 for data 0005 loaded on release, blink_mask=0001.
   logic [6:0] blink_exp [12] = '{7'h40, 7'h12, 7'h12, 7'h12, 7'h7F, 7'h7F,
                                  7'h7F, 7'h7F, 7'h12, 7'h12, 7'h12, 7'h12};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Displayed pattern of digit k, from the rules: leading-zero blank for
   // k>=1, blink blank in odd half-periods, otherwise the hex glyph.
   function automatic logic [6:0] model_digit(input int k, input int data, input bit lz,
                                              input logic [3:0] mask, input int e);
      bit blank;
      blank = 1'b0;
      if (lz && k >= 1 && (data >> (4 * k)) == 0) blank = 1'b1;
      if (mask[k] && ((e / BD) % 2) == 1) blank = 1'b1;
      return blank ? 7'h7F : seg_lut[(data >> (4 * k)) & 15];
   endfunction

   // One clock: model update at the rising edge, compare at the falling edge.
   task automatic tick();
      int idx;
      @(posedge clk);
      if (!reset_n) begin
         m_data       = 0;
         m_edges      = 0;
         m_valid      = 1'b1;
         exp_seg_all  = '1;
         exp_scan_seg = 7'h7F;
         exp_scan_an  = '1;
      end else begin
         for (int k = 0; k < ND; k++)
            exp_seg_all[7*k +: 7] = model_digit(k, m_data, lz_blank, blink_mask, m_edges);
         idx          = (m_edges / SD) % ND;
         exp_scan_seg = model_digit(idx, m_data, lz_blank, blink_mask, m_edges);
         exp_scan_an  = '1;
         exp_scan_an[idx] = 1'b0;
         if (load) m_data = int'(data_in);
         m_edges++;
      end
      @(negedge clk);
      $display("t=%0t rst_n=%b ld=%b din=%h lz=%b bm=%b seg_all=%h scan_an=%b scan_seg=%h",
               $time, reset_n, load, data_in, lz_blank, blink_mask, seg_all, scan_an, scan_seg);
      if (m_valid) begin
         check("model_seg_all",  32'(seg_all),  32'(exp_seg_all));
         check("model_scan_seg", 32'(scan_seg), 32'(exp_scan_seg));
         check("model_scan_an",  32'(scan_an),  32'(exp_scan_an));
      end
   endtask

   task automatic load_and_settle(input logic [15:0] value);
      data_in = value;
      load    = 1'b1;
      tick();
      load    = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      load    = 1'b0;
      tick();
      tick();
      check("reset_seg_all",  32'(seg_all),  32'h0FFF_FFFF);
      check("reset_scan_seg", 32'(scan_seg), 32'h7F);
      check("reset_scan_an",  32'(scan_an),  32'hF);
   endtask

   initial begin
      int  n;
      // Reset and first edge after release
      do_reset();
      reset_n = 1'b1;
      tick();
      check("first_seg_all",  32'(seg_all),  32'(28'h810_2040));   // 40 in every digit
      check("first_scan_an",  32'(scan_an),  32'hE);
      check("first_scan_seg", 32'(scan_seg), 32'h40);

      // Plain decode, no blanking
      load_and_settle(16'h1A0F);
      check("load_1A0F", 32'(seg_all), 32'({7'h79, 7'h08, 7'h40, 7'h0E}));

      // Leading-zero blanking
      lz_blank = 1'b1;
      load_and_settle(16'h00B0);
      check("lz_00B0", 32'(seg_all), 32'({7'h7F, 7'h7F, 7'h03, 7'h40}));
      load_and_settle(16'h0000);
      check("lz_0000", 32'(seg_all), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));
      load_and_settle(16'h1000);
      check("lz_1000", 32'(seg_all), 32'({7'h79, 7'h40, 7'h40, 7'h40}));
      load_and_settle(16'h0100);
      check("lz_0100", 32'(seg_all), 32'({7'h7F, 7'h79, 7'h40, 7'h40}));
      lz_blank = 1'b0;

      // Blink on digit 0, data loaded on the release edge
      do_reset();
      blink_mask = 4'b0001;
      reset_n    = 1'b1;
      data_in    = 16'h0005;
      load       = 1'b1;
      for (int e = 0; e < 12; e++) begin
         tick();
         load = 1'b0;
         check("blink_digit0", 32'(seg_all[6:0]), 32'(blink_exp[e]));
         check("blink_steady", 32'(seg_all[27:7]), 32'({7'h40, 7'h40, 7'h40}));
      end
      blink_mask = 4'b0000;

      // Scan sequence for 4321
      do_reset();
      reset_n = 1'b1;
      data_in = 16'h4321;
      load    = 1'b1;
      for (int e = 0; e < 10; e++) begin
         tick();
         load = 1'b0;
         check("scan_an",  32'(scan_an),  32'(scan_exp_an[e]));
         check("scan_seg", 32'(scan_seg), 32'(scan_exp_seg[e]));
      end

      // Run on to digit 2, then reset together with a load of FFFF
      n = 0;
      while (scan_an != 4'b1011 && n < 20) begin
         tick();
         n++;
      end
      check("reach_digit2_in_budget", 32'(n < 20), 32'd1);
      reset_n = 1'b0;
      data_in = 16'hFFFF;
      load    = 1'b1;
      tick();
      check("midreset_seg_all",  32'(seg_all),  32'h0FFF_FFFF);
      check("midreset_scan_seg", 32'(scan_seg), 32'h7F);
      check("midreset_scan_an",  32'(scan_an),  32'hF);
      reset_n = 1'b1;
      load    = 1'b0;
      tick();
      check("restart_scan_an",  32'(scan_an),  32'hE);
      check("restart_scan_seg", 32'(scan_seg), 32'h40);
      check("restart_seg_all",  32'(seg_all),  32'(28'h810_2040));
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Parametrised, clocked seven-segment display controller for N hexadecimal digits. Latches a packed nibble vector on a load strobe and drives two outputs. One is every digit in parallel, for boards with dedicated HEX pins. The other is a time-multiplexed single-digit bus with one-hot digit enables, for scanned displays. Adds leading-zero blanking and per-digit blinking. Sits between the datapath's debug/result bus and the board display pins in the top-level wrapper.

## Interface
- NUM_DIGITS, 8, number of hex digits displayed (1..16)
- SCAN_DIV, 50000, clock cycles each digit is held on the scanned bus (>=1)
- BLINK_DIV, 25000000, clock cycles per blink half-period (>=1)
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- load  in  1  capture data_in this cycle
- data_in  in  4*NUM_DIGITS  packed nibbles, digit 0 = [3:0], digit k = [4k+3:4k]
- lz_blank  in  1  enable leading-zero blanking (live, not latched)
- blink_mask  in  NUM_DIGITS  bit k set: digit k blinks (live, not latched)
- seg_all  out  7*NUM_DIGITS  active-low segments, digit k at [7k+6:7k], bit order g..a ([6]=g, [0]=a)
- scan_seg  out  7  active-low segments of the currently scanned digit
- scan_an  out  NUM_DIGITS  active-low one-hot digit enable

## Operation
- Decode, active-low g..a:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
  - Blank = 7'h7F.
- data_reg (4*NUM_DIGITS): loads data_in when load=1, otherwise holds.
- Leading-zero blanking: when lz_blank=1, digit k is blank if every nibble k..NUM_DIGITS-1 of data_reg is zero, for k>=1. Digit 0 is never blanked by this rule, so an all-zero value shows a single "0".
- Blink engine: blink_cnt counts 0..BLINK_DIV-1 and wraps. blink_phase toggles on each wrap. Digit k is blank when blink_mask[k]=1 and blink_phase=0. load does not affect blink_cnt or blink_phase.
- A digit is blank if either rule blanks it.
- Scan engine:
  - scan_cnt counts 0..SCAN_DIV-1. On its wrap, scan_idx increments.
  - scan_idx wraps from NUM_DIGITS-1 to 0. When NUM_DIGITS=1 it stays at 0.
  - scan_an = ~(1<<scan_idx). scan_seg = the final per-digit value of digit scan_idx, blanking included.
- All three outputs are registered.

## Timing
- Reset (reset_n=0 at a rising edge):
  - data_reg=0, blink_cnt=0, blink_phase=1 (visible), scan_cnt=0, scan_idx=0.
  - seg_all all-ones, scan_seg=7'h7F, scan_an all-ones.
  - Reset wins over a simultaneous load.
- First edge after release: outputs reflect data_reg=0.
  - seg_all = 7'h40 per digit, or digit 0 only when lz_blank=1.
  - scan_an = ~1, scan_seg = digit 0.
- Load latency: load sampled at edge N. data_reg updates at N, and seg_all/scan_seg reflect it after edge N+1 (2-edge latency). Back-to-back loads: the last one wins; every load is honoured in order.
- Live-input latency: lz_blank/blink_mask changes appear on outputs after 1 edge.
- Blink timing: blink_phase first toggles at the edge where blink_cnt wraps, i.e. BLINK_DIV edges after reset release. The output change follows 1 edge later.
- Scan timing:
  - scan_idx advances every SCAN_DIV edges. With SCAN_DIV=1 it advances every edge.
  - scan_an/scan_seg for the new index appear 1 edge after the advance. The pair is always mutually consistent, never mixing the anode of one digit with the segments of another.
- Reset mid-scan or mid-blink: returns immediately to the reset state above; no partial state survives.

## Test plan
- Bench parameters: NUM_DIGITS=4, SCAN_DIV=2, BLINK_DIV=4.
- Reset then load 16'h1A0F with lz_blank=0 → after 2 edges seg_all = {7'h79,7'h08,7'h40,7'h0E} (digit3..0).
- Load 16'h00B0 with lz_blank=1 → seg_all = {7'h7F,7'h7F,7'h03,7'h40}. Load 16'h0000 → {7'h7F,7'h7F,7'h7F,7'h40}.
- Free-run with data 16'h4321 → scan_an sequence 1110,1101,1011,0111,1110 (each held 2 cycles), with scan_seg 7'h79,7'h24,7'h30,7'h19 aligned to each anode.
- blink_mask=4'b0001, data 16'h0005 → digit 0 alternates 7'h12 / 7'h7F every 4 cycles, first blank 5 edges after reset release. Digits 1..3 stay steady 7'h40.
- Assert reset_n=0 together with load of 16'hFFFF mid-scan (scan_idx=2) → next edge all outputs all-ones, data_reg=0. After release the scan restarts at digit 0 with 7'h40.
